// File: rtl/fde_skid_buffer.sv
// Two-entry elastic buffer between fetch/decode and execute.
// Upstream ready is a flop, so out_ready never reaches in_ready combinationally.
module fde_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_in_ready;
    logic             r_overflow;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_consume;
    logic             w_overflow_evt;

    assign w_out_valid    = (r_state != S_EMPTY);
    assign w_accept       = in_valid & r_in_ready;
    assign w_consume      = w_out_valid & out_ready;
    assign w_overflow_evt = in_valid & ~r_in_ready & ~flush;

    // Skid only ever fills when main is occupied and not draining, so main stays the oldest word.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_nxt  = in_data;
                    end else if (w_accept) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = S_TWO;
                    end else if (w_consume) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_consume) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
            r_overflow <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_state;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_fde_skid_buffer.sv
// Bench for fde_skid_buffer: directed steps followed by random traffic,
// compared each cycle against a queue-based model of a two-deep FIFO.
module tb_fde_skid_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_q[$];
    logic        m_rdy;
    logic        m_ovf;
    bit          seen_c;

    fde_skid_buffer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rdy = 1'b1;
        m_ovf = 1'b0;
    endtask

    // Capacity-two FIFO; ready seen upstream is whether there was room after the previous edge.
    task automatic model_edge();
        logic acc;
        logic con;
        acc = in_valid & m_rdy;
        con = (m_q.size() > 0) & out_ready;
        if (in_valid && !m_rdy && !flush) m_ovf = 1'b1;
        if (flush) begin
            m_q.delete();
        end else begin
            if (con) void'(m_q.pop_front());
            if (acc) m_q.push_back(in_data);
        end
        m_rdy = (m_q.size() < 2);
    endtask

    task automatic check_all(input string where);
        chk({where, ":out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
        chk({where, ":in_ready"},  32'(in_ready),  32'(m_rdy));
        chk({where, ":occupancy"}, 32'(occupancy), 32'(m_q.size()));
        chk({where, ":overflow"},  32'(overflow),  32'(m_ovf));
        if (m_q.size() > 0) chk({where, ":out_data"}, out_data, m_q[0]);
    endtask

    task automatic cycle(input string where, input logic v, input logic [31:0] d,
                         input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        model_edge();
        #1;
        if (out_valid && out_data == 32'h0000000C) seen_c = 1'b1;
        check_all(where);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        seen_c    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset:out_data", out_data, 32'h0);
        check_all("reset");
        #3 rst_n = 1'b1;

        cycle("first", 1'b1, 32'h00000013, 1'b1, 1'b0);
        chk("first:word", out_data, 32'h00000013);
        chk("first:occ", 32'(occupancy), 32'd1);

        cycle("stream1", 1'b1, 32'h1, 1'b1, 1'b0);
        chk("stream1:word", out_data, 32'h1);
        cycle("stream2", 1'b1, 32'h2, 1'b1, 1'b0);
        chk("stream2:word", out_data, 32'h2);
        cycle("stream3", 1'b1, 32'h3, 1'b1, 1'b0);
        chk("stream3:word", out_data, 32'h3);
        chk("stream3:ready", 32'(in_ready), 32'd1);
        cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0);

        cycle("stallA", 1'b1, 32'hA, 1'b0, 1'b0);
        cycle("stallB", 1'b1, 32'hB, 1'b0, 1'b0);
        chk("stall:ready", 32'(in_ready), 32'd0);
        chk("stall:occ", 32'(occupancy), 32'd2);
        chk("stall:hold", out_data, 32'hA);
        cycle("stall_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall:stable", out_data, 32'hA);
        cycle("popA", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("popA:word", out_data, 32'hB);
        chk("popA:ready", 32'(in_ready), 32'd1);
        cycle("popB", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("popB:empty", 32'(out_valid), 32'd0);

        cycle("refillA", 1'b1, 32'hA, 1'b0, 1'b0);
        cycle("refillB", 1'b1, 32'hB, 1'b0, 1'b0);
        cycle("ovf", 1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("ovf:flag", 32'(overflow), 32'd1);
        chk("ovf:head", out_data, 32'hA);
        cycle("ovf_sticky", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("ovf:next", out_data, 32'hB);
        chk("ovf:still", 32'(overflow), 32'd1);

        cycle("fillX", 1'b1, 32'h11, 1'b0, 1'b0);
        cycle("fillY", 1'b0, 32'h0, 1'b0, 1'b0);
        seen_c = 1'b0;
        cycle("flush", 1'b1, 32'h0000000C, 1'b1, 1'b1);
        chk("flush:valid", 32'(out_valid), 32'd0);
        chk("flush:occ", 32'(occupancy), 32'd0);
        chk("flush:ready", 32'(in_ready), 32'd1);
        cycle("postflush", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush:no_c", 32'(seen_c), 32'd0);

        cycle("arA", 1'b1, 32'h21, 1'b0, 1'b0);
        cycle("arB", 1'b1, 32'h22, 1'b0, 1'b0);
        chk("ar:occ_before", 32'(occupancy), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar:out_data", out_data, 32'h0);
        check_all("async_rst");
        in_valid = 1'b1;
        in_data  = 32'h33;
        @(posedge clk);
        #1;
        check_all("rst_held");
        #3 rst_n = 1'b1;
        cycle("post_rst", 1'b1, 32'h33, 1'b0, 1'b0);
        chk("post_rst:word", out_data, 32'h33);

        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
